// File: rtl/instr_encoder.sv
// RV64 instruction encoder: turns field bundles into 32-bit words with
// sequential addresses, using a valid/ready handshake on both sides.
module instr_encoder #(
  parameter int MAX_INSTR = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] baseAddr,
  input  logic        inValid,
  output logic        inReady,
  input  logic [2:0]  opSel,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic        outValid,
  input  logic        outReady,
  output logic [31:0] instruction,
  output logic [63:0] instrAddr,
  output logic [15:0] count,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  localparam logic [16:0] MAX_ACC = 17'(MAX_INSTR);
  localparam logic [15:0] MAX_CNT = 16'(MAX_INSTR);

  state_t      state;
  logic [63:0] next_addr;
  logic [16:0] acc_cnt;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        accept;
  logic        xfer;

  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    case (opSel)
      3'd0: enc_word = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd1: enc_word = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
      3'd2: enc_word = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
      3'd3: enc_word = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
      3'd4: begin
        // offset must fit the 12-bit signed field
        enc_illegal = imm[12] ^ imm[11];
        enc_word    = {imm[11:0], rs1, 3'b011, rd, 7'b0000011};
      end
      3'd5: begin
        enc_illegal = imm[12] ^ imm[11];
        enc_word    = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
      end
      3'd6: begin
        enc_illegal = imm[0];
        enc_word    = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
      end
      default: enc_illegal = 1'b1;
    endcase
  end

  assign inReady = (state == RUN) && !start && (acc_cnt < MAX_ACC) && (!outValid || outReady);
  assign accept  = inValid && inReady;
  assign xfer    = outValid && outReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      outValid    <= 1'b0;
      instruction <= '0;
      instrAddr   <= '0;
      count       <= '0;
      error       <= 1'b0;
      next_addr   <= '0;
      acc_cnt     <= '0;
    end else if (start) begin
      state     <= RUN;
      outValid  <= 1'b0;
      count     <= '0;
      error     <= 1'b0;
      next_addr <= baseAddr;
      acc_cnt   <= '0;
    end else begin
      if (xfer) begin
        outValid <= 1'b0;
        count    <= count + 16'd1;
      end
      // a legal accept reloads outValid after any same-cycle transfer cleared it
      if (accept) begin
        if (enc_illegal) begin
          error <= 1'b1;
          state <= ERR;
        end else begin
          outValid    <= 1'b1;
          instruction <= enc_word;
          instrAddr   <= next_addr;
          next_addr   <= next_addr + 64'd4;
          acc_cnt     <= acc_cnt + 17'd1;
        end
      end else if (state == RUN && count == MAX_CNT && !outValid) begin
        state <= DONE;
      end
    end
  end

endmodule
